// File: rtl/ber_pkg.sv
// Shared definitions for the PRBS7 bit-error-rate counter: accumulator widths,
// generator taps, checker state encoding and saturating-increment helpers.
package ber_pkg;

    localparam int RCNT_W   = 60;
    localparam int ECNT_W   = 64;
    localparam int PRBS_LEN = 7;
    localparam int TAP_A    = 6;
    localparam int TAP_B    = 5;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } chk_state_t;

    function automatic logic prbs7_predict(input logic [PRBS_LEN-1:0] r);
        return r[TAP_A] ^ r[TAP_B];
    endfunction

    function automatic logic [RCNT_W-1:0] sat_inc_rcnt(input logic [RCNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + RCNT_W'(1'b1);
        end
    endfunction

    function automatic logic [ECNT_W-1:0] sat_inc_ecnt(input logic [ECNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + ECNT_W'(1'b1);
        end
    endfunction

endpackage

// File: rtl/ber_counter_if.sv
// Bit stream in, display handshake out: the signals shared between the BER
// counter (master) and its stream source / 7-segment display block (slave).
interface ber_counter_if;
    import ber_pkg::*;

    logic              DIN_VALID;
    logic              DIN;
    logic              CLEAR;
    logic              BUSY;
    logic              START;
    logic [RCNT_W-1:0] RECV_CNT;
    logic [ECNT_W-1:0] ERR_CNT;
    logic              LOCKED;

    modport master (
        input  DIN_VALID, DIN, CLEAR, BUSY,
        output START, RECV_CNT, ERR_CNT, LOCKED
    );

    modport slave (
        output DIN_VALID, DIN, CLEAR, BUSY,
        input  START, RECV_CNT, ERR_CNT, LOCKED
    );

endinterface

// File: rtl/ber_counter_prbs7_chk.sv
// Self-synchronising PRBS7 checker: hunts, verifies and then free-runs a
// reference LFSR, flagging each counted bit and whether it was in error.
module prbs7_chk
    import ber_pkg::*;
#(
    parameter int LOCK_CNT = 32,
    parameter int WIN_LEN  = 64,
    parameter int LOSS_THR = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din_valid,
    input  logic din,
    output logic cnt_en,
    output logic err,
    output logic locked
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W   = $clog2(WIN_LEN);
    localparam int WERR_W  = $clog2(LOSS_THR + 1);

    chk_state_t           state_r, state_nxt_s;
    logic [PRBS_LEN-1:0]  shreg_r, shreg_nxt_s;
    logic [2:0]           fill_r, fill_nxt_s;
    logic [MATCH_W-1:0]   match_r, match_nxt_s;
    logic [WIN_W-1:0]     win_r, win_nxt_s;
    logic [WERR_W-1:0]    werr_r, werr_nxt_s, werr_inc_s;
    logic                 locked_r;
    logic                 pred_s;
    logic                 mis_s;

    assign pred_s = prbs7_predict(shreg_r);
    assign mis_s  = din ^ pred_s;
    assign cnt_en = din_valid && (state_r == ST_LOCKED);
    assign err    = cnt_en && mis_s;
    assign locked = locked_r;

    // Next-state logic: acquisition, verification and loss-of-lock windowing
    always_comb begin
        state_nxt_s = state_r;
        shreg_nxt_s = shreg_r;
        fill_nxt_s  = fill_r;
        match_nxt_s = match_r;
        win_nxt_s   = win_r;
        werr_nxt_s  = werr_r;
        werr_inc_s  = werr_r + WERR_W'(mis_s);
        if (din_valid) begin
            case (state_r)
                ST_HUNT: begin
                    shreg_nxt_s = {shreg_r[PRBS_LEN-2:0], din};
                    if (fill_r == 3'(PRBS_LEN - 1)) begin
                        state_nxt_s = ST_CHECK;
                        fill_nxt_s  = 3'd0;
                        match_nxt_s = '0;
                    end else begin
                        fill_nxt_s = fill_r + 3'd1;
                    end
                end
                ST_CHECK: begin
                    shreg_nxt_s = {shreg_r[PRBS_LEN-2:0], din};
                    if (mis_s) begin
                        state_nxt_s = ST_HUNT;
                        fill_nxt_s  = 3'd0;
                    end else if (match_r == MATCH_W'(LOCK_CNT - 1)) begin
                        state_nxt_s = ST_LOCKED;
                        match_nxt_s = '0;
                        win_nxt_s   = '0;
                        werr_nxt_s  = '0;
                    end else begin
                        match_nxt_s = match_r + MATCH_W'(1'b1);
                    end
                end
                ST_LOCKED: begin
                    // Reference free-runs so injected errors cannot corrupt it
                    shreg_nxt_s = {shreg_r[PRBS_LEN-2:0], pred_s};
                    win_nxt_s   = win_r + WIN_W'(1'b1);
                    if (werr_inc_s == WERR_W'(LOSS_THR)) begin
                        state_nxt_s = ST_HUNT;
                        fill_nxt_s  = 3'd0;
                        werr_nxt_s  = '0;
                    end else if (win_r == WIN_W'(WIN_LEN - 1)) begin
                        werr_nxt_s = '0;
                    end else begin
                        werr_nxt_s = werr_inc_s;
                    end
                end
                default: begin
                    state_nxt_s = ST_HUNT;
                    fill_nxt_s  = 3'd0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State and counter registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_HUNT;
            shreg_r  <= '0;
            fill_r   <= 3'd0;
            match_r  <= '0;
            win_r    <= '0;
            werr_r   <= '0;
            locked_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            shreg_r  <= shreg_nxt_s;
            fill_r   <= fill_nxt_s;
            match_r  <= match_nxt_s;
            win_r    <= win_nxt_s;
            werr_r   <= werr_nxt_s;
            locked_r <= (state_nxt_s == ST_LOCKED);
        end
    end

endmodule

// File: rtl/ber_counter.sv
// BER counter top: saturating received/error accumulators plus a periodic
// snapshot published to the display with a one-cycle START pulse.
module ber_counter
    import ber_pkg::*;
#(
    parameter int UPD_PERIOD = 50000000,
    parameter int LOCK_CNT   = 32,
    parameter int WIN_LEN    = 64,
    parameter int LOSS_THR   = 16
) (
    input  logic          CLK,
    input  logic          RSTX,
    ber_counter_if.master bus
);

    localparam int PER_W = (UPD_PERIOD > 2) ? $clog2(UPD_PERIOD) : 1;

    logic              cnt_en_s;
    logic              err_s;
    logic              locked_s;
    logic [RCNT_W-1:0] rcnt_r, rcnt_nxt_s;
    logic [ECNT_W-1:0] ecnt_r, ecnt_nxt_s;
    logic [PER_W-1:0]  per_r, per_nxt_s;
    logic              pend_r, pend_nxt_s;
    logic              wrap_s;
    logic              snap_s;
    logic              start_r;
    logic [RCNT_W-1:0] recv_snap_r;
    logic [ECNT_W-1:0] err_snap_r;

    prbs7_chk #(
        .LOCK_CNT (LOCK_CNT),
        .WIN_LEN  (WIN_LEN),
        .LOSS_THR (LOSS_THR)
    ) u_chk (
        .clk       (CLK),
        .rst_n     (RSTX),
        .din_valid (bus.DIN_VALID),
        .din       (bus.DIN),
        .cnt_en    (cnt_en_s),
        .err       (err_s),
        .locked    (locked_s)
    );

    assign bus.START    = start_r;
    assign bus.RECV_CNT = recv_snap_r;
    assign bus.ERR_CNT  = err_snap_r;
    assign bus.LOCKED   = locked_s;

    // Accumulator update, period timer and snapshot request handshake
    always_comb begin
        rcnt_nxt_s = rcnt_r;
        ecnt_nxt_s = ecnt_r;
        if (bus.CLEAR) begin
            rcnt_nxt_s = '0;
            ecnt_nxt_s = '0;
        end else begin
            if (cnt_en_s) begin
                rcnt_nxt_s = sat_inc_rcnt(rcnt_r);
            end else begin
                rcnt_nxt_s = rcnt_r;
            end
            if (err_s) begin
                ecnt_nxt_s = sat_inc_ecnt(ecnt_r);
            end else begin
                ecnt_nxt_s = ecnt_r;
            end
        end
        wrap_s = (per_r == PER_W'(UPD_PERIOD - 1));
        if (wrap_s) begin
            per_nxt_s = '0;
        end else begin
            per_nxt_s = per_r + PER_W'(1'b1);
        end
        // A fresh wrap re-arms the request; otherwise only BUSY keeps it alive
        snap_s     = pend_r && !bus.BUSY;
        pend_nxt_s = wrap_s || (pend_r && bus.BUSY);
    end

    // Registered accumulators and display-facing snapshot outputs
    always_ff @(posedge CLK) begin
        if (!RSTX) begin
            rcnt_r      <= '0;
            ecnt_r      <= '0;
            per_r       <= '0;
            pend_r      <= 1'b0;
            start_r     <= 1'b0;
            recv_snap_r <= '0;
            err_snap_r  <= '0;
        end else begin
            rcnt_r  <= rcnt_nxt_s;
            ecnt_r  <= ecnt_nxt_s;
            per_r   <= per_nxt_s;
            pend_r  <= pend_nxt_s;
            start_r <= snap_s;
            if (snap_s) begin
                recv_snap_r <= rcnt_r;
                err_snap_r  <= ecnt_r;
            end
        end
    end

endmodule

// File: tb/tb_ber_counter.sv
// Self-checking bench for ber_counter: a behavioural model queues each expected
// snapshot when stimulus is driven and compares it when START is observed.
module tb_ber_counter;

    localparam int PERIOD = 100;
    localparam logic [59:0] RMAX = 60'hFFF_FFFF_FFFF_FFFF;
    localparam logic [59:0] RSAT2 = 60'hFFF_FFFF_FFFF_FFFE;

    logic clk;
    logic rstx;
    ber_counter_if bif ();

    ber_counter #(.UPD_PERIOD(PERIOD)) dut (
        .CLK  (clk),
        .RSTX (rstx),
        .bus  (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_start = 0;
    logic [59:0] last_recv;
    logic [63:0] last_err;

    // Behavioural model state
    logic [6:0]   gen;
    logic [59:0]  m_rcnt;
    logic [63:0]  m_ecnt;
    int           m_per;
    logic         m_pend;
    logic         m_locked;
    int           m_hcnt;
    int           m_win;
    int           m_werr;
    logic [123:0] q[$];

    task automatic step(input logic v, input logic inj, input logic clr, input logic bsy);
        logic b;
        logic exp_start;
        logic [123:0] e;
        @(negedge clk);
        b = 1'b0;
        if (v) begin
            b   = gen[6] ^ gen[5];
            gen = {gen[5:0], b};
            b   = b ^ inj;
        end
        bif.DIN_VALID = v;
        bif.DIN       = b;
        bif.CLEAR     = clr;
        bif.BUSY      = bsy;
        exp_start = m_pend && !bsy;
        if (exp_start) q.push_back({m_rcnt, m_ecnt});
        m_pend = (m_per == PERIOD - 1) || (m_pend && bsy);
        m_per  = (m_per == PERIOD - 1) ? 0 : m_per + 1;
        if (v) begin
            if (m_locked) begin
                if (m_rcnt != RMAX) m_rcnt = m_rcnt + 60'd1;
                if (inj) begin
                    if (m_ecnt != 64'hFFFF_FFFF_FFFF_FFFF) m_ecnt = m_ecnt + 64'd1;
                    m_werr++;
                end
                if (m_werr >= 16) begin
                    m_locked = 1'b0;
                    m_hcnt   = 0;
                    m_werr   = 0;
                end else if (m_win == 63) begin
                    m_werr = 0;
                end
                m_win = (m_win + 1) % 64;
            end else begin
                m_hcnt++;
                if (m_hcnt == 39) begin
                    m_locked = 1'b1;
                    m_hcnt   = 0;
                    m_win    = 0;
                    m_werr   = 0;
                end
            end
        end
        if (clr) begin
            m_rcnt = '0;
            m_ecnt = '0;
        end
        @(posedge clk);
        #1;
        checks++;
        if (bif.START !== exp_start) begin
            errors++;
            $display("FAIL start: got %b expected %b at %0t", bif.START, exp_start, $time);
        end
        if (bif.START === 1'b1) begin
            n_start++;
            last_recv = bif.RECV_CNT;
            last_err  = bif.ERR_CNT;
        end
        if (q.size() != 0 && (bif.START === 1'b1 || exp_start)) begin
            e = q.pop_front();
            if (bif.START === 1'b1) begin
                checks += 2;
                if (bif.RECV_CNT !== e[123:64]) begin
                    errors++;
                    $display("FAIL snap_recv: got %0d expected %0d", bif.RECV_CNT, e[123:64]);
                end
                if (bif.ERR_CNT !== e[63:0]) begin
                    errors++;
                    $display("FAIL snap_err: got %0d expected %0d", bif.ERR_CNT, e[63:0]);
                end
            end
        end
        checks++;
        if (bif.LOCKED !== m_locked) begin
            errors++;
            $display("FAIL locked: got %b expected %b at %0t", bif.LOCKED, m_locked, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstx = 1'b0;
        bif.DIN_VALID = 1'b0;
        bif.DIN = 1'b0;
        bif.CLEAR = 1'b0;
        bif.BUSY = 1'b0;
        m_rcnt = '0; m_ecnt = '0; m_per = 0; m_pend = 1'b0;
        m_locked = 1'b0; m_hcnt = 0; m_win = 0; m_werr = 0;
        q.delete();
        @(posedge clk);
        #1;
        rstx = 1'b1;
        checks += 4;
        if (bif.START !== 1'b0) begin errors++; $display("FAIL rst_start: got %b expected 0", bif.START); end
        if (bif.LOCKED !== 1'b0) begin errors++; $display("FAIL rst_locked: got %b expected 0", bif.LOCKED); end
        if (bif.RECV_CNT !== 60'd0) begin errors++; $display("FAIL rst_recv: got %0d expected 0", bif.RECV_CNT); end
        if (bif.ERR_CNT !== 64'd0) begin errors++; $display("FAIL rst_err: got %0d expected 0", bif.ERR_CNT); end
    endtask

    // Step with DIN_VALID low until a START appears; a missing START is a failure
    task automatic wait_start(input string name);
        int s0;
        s0 = n_start;
        for (int i = 0; i < 150; i++) begin
            if (n_start == s0) step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (n_start == s0) begin
            errors++;
            $display("FAIL %s: got no START expected one within 150 cycles", name);
        end
    endtask

    task automatic test_reset();
        gen = 7'h7F;
        rstx = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();
    endtask

    task automatic test_lock();
        int lock_at;
        int k;
        int s0;
        lock_at = 0;
        for (int i = 1; i <= 80; i++) begin
            if (lock_at == 0) begin
                step(1'b1, 1'b0, 1'b0, 1'b0);
                if (bif.LOCKED === 1'b1) lock_at = i;
            end
        end
        checks++;
        if (lock_at != 39) begin errors++; $display("FAIL lock_bits: got %0d expected 39", lock_at); end
        k = -1;
        s0 = n_start;
        for (int i = 0; i < 200; i++) begin
            if (n_start == s0) begin
                step(1'b1, 1'b0, 1'b0, 1'b0);
                if (n_start != s0) k = i;
            end
        end
        checks += 2;
        if (k < 0 || last_recv !== 60'(k)) begin
            errors++;
            $display("FAIL first_recv: got %0d expected %0d", last_recv, k);
        end
        if (last_err !== 64'd0) begin errors++; $display("FAIL first_err: got %0d expected 0", last_err); end
    endtask

    task automatic test_errors();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10000; i++) begin
            step(1'b1, (i % 100) == 99, 1'b0, 1'b0);
        end
        wait_start("err_wait");
        checks += 3;
        if (last_recv !== 60'd10000) begin errors++; $display("FAIL err_recv: got %0d expected 10000", last_recv); end
        if (last_err !== 64'd100) begin errors++; $display("FAIL err_ecnt: got %0d expected 100", last_err); end
        if (bif.LOCKED !== 1'b1) begin errors++; $display("FAIL err_locked: got %b expected 1", bif.LOCKED); end
    endtask

    task automatic test_back_to_back_busy();
        int s0;
        for (int i = 0; i < 100; i++) begin
            if (m_per != 10) step(1'b1, 1'b0, 1'b0, 1'b0);
        end
        s0 = n_start;
        repeat (250) step(1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (n_start != s0) begin errors++; $display("FAIL busy_block: got %0d starts expected 0", n_start - s0); end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bif.START !== 1'b1) begin errors++; $display("FAIL busy_release: got %b expected 1", bif.START); end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bif.START !== 1'b0) begin errors++; $display("FAIL busy_single: got %b expected 0", bif.START); end
    endtask

    task automatic test_loss();
        logic [59:0] fr;
        logic [63:0] fe;
        int relock;
        for (int i = 0; i < 64; i++) begin
            if (m_win != 0) step(1'b1, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            if (i == 15) begin
                checks++;
                if (bif.LOCKED !== 1'b1) begin errors++; $display("FAIL loss_early: got %b expected 1", bif.LOCKED); end
            end
        end
        checks++;
        if (bif.LOCKED !== 1'b0) begin errors++; $display("FAIL loss_drop: got %b expected 0", bif.LOCKED); end
        fr = m_rcnt;
        fe = m_ecnt;
        wait_start("loss_wait");
        checks += 2;
        if (last_recv !== fr) begin errors++; $display("FAIL loss_frz_recv: got %0d expected %0d", last_recv, fr); end
        if (last_err !== fe) begin errors++; $display("FAIL loss_frz_err: got %0d expected %0d", last_err, fe); end
        relock = 0;
        for (int i = 1; i <= 80; i++) begin
            if (relock == 0) begin
                step(1'b1, 1'b0, 1'b0, 1'b0);
                if (bif.LOCKED === 1'b1) relock = i;
            end
        end
        checks++;
        if (relock != 39) begin errors++; $display("FAIL relock_bits: got %0d expected 39", relock); end
        repeat (150) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_clear();
        int k;
        int s0;
        step(1'b1, 1'b1, 1'b1, 1'b0);
        k = -1;
        s0 = n_start;
        for (int i = 0; i < 200; i++) begin
            if (n_start == s0) begin
                step(1'b1, 1'b0, 1'b0, 1'b0);
                if (n_start != s0) k = i;
            end
        end
        checks += 2;
        if (k < 0 || last_recv !== 60'(k)) begin
            errors++;
            $display("FAIL clr_recv: got %0d expected %0d", last_recv, k);
        end
        if (last_err !== 64'd0) begin errors++; $display("FAIL clr_err: got %0d expected 0", last_err); end
    endtask

    task automatic test_saturation_reset();
        int s0;
        force dut.rcnt_r = RSAT2;
        m_rcnt = RSAT2;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        release dut.rcnt_r;
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
        wait_start("sat_wait");
        checks++;
        if (last_recv !== RMAX) begin errors++; $display("FAIL sat_recv: got %0h expected %0h", last_recv, RMAX); end
        for (int i = 0; i < 150; i++) begin
            if (!m_pend) step(1'b1, 1'b0, 1'b0, 1'b1);
        end
        checks++;
        if (!m_pend) begin errors++; $display("FAIL pend_setup: got 0 expected 1"); end
        do_reset();
        s0 = n_start;
        repeat (50) step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (n_start != s0) begin errors++; $display("FAIL pend_discard: got %0d starts expected 0", n_start - s0); end
    endtask

    initial begin
        rstx = 1'b0;
        bif.DIN_VALID = 1'b0;
        bif.DIN = 1'b0;
        bif.CLEAR = 1'b0;
        bif.BUSY = 1'b0;
        test_reset();
        test_lock();
        test_errors();
        test_back_to_back_busy();
        test_loss();
        test_clear();
        test_saturation_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
